// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM port sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Granted request, word-aligned base kept without its always-zero low bits.
  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [29:0] word;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// Picks the next byte lane to visit: highest selected lane not yet visited.
module mem_lane_sel (
  input  logic [3:0] sel,
  input  logic [3:0] visited,
  output logic [1:0] lane,
  output logic       any,
  output logic       last
);

  logic [3:0] pending;

  always_comb begin
    pending = sel & ~visited;
    lane    = 2'd0;
    any     = 1'b0;
    // Ascending scan so the highest pending lane is the one left standing.
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) begin
        lane = 2'(i);
        any  = 1'b1;
      end
    end
    last = any && ((pending & ~(4'b0001 << lane)) == 4'b0000);
  end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between IF and MEM (MEM first, no preemption), serialising words into bytes.
// Reads issue one address per cycle and complete RD_LAT cycles after the last; done/data are registered pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        stall_req_o
);

  mc_state_t   state, state_nxt;
  req_t        req_in, cur;
  owner_t      grant_owner;
  logic [3:0]  visited;
  logic [2:0]  cap_cnt;
  logic        pipe_vld  [RD_LAT];
  logic [1:0]  pipe_lane [RD_LAT];
  logic [31:0] asm_q, asm_nxt;
  logic [1:0]  lane;
  logic        lane_any, lane_last;
  logic        issue, capture, cap_last, fin;
  logic [31:0] if_data_q, mem_data_q;
  logic        if_done_q, mem_done_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr_i[1:0], mem_addr_i[1:0]};

  mem_lane_sel u_lane_sel (
    .sel     (cur.sel),
    .visited (visited),
    .lane    (lane),
    .any     (lane_any),
    .last    (lane_last)
  );

  always_comb begin
    req_in = '0;
    if (mem_ce_i) begin
      req_in.owner = OWN_MEM;
      req_in.we    = mem_we_i;
      req_in.word  = mem_addr_i[31:2];
      req_in.sel   = mem_sel_i;
      req_in.wdata = mem_data_i;
    end else begin
      req_in.owner = OWN_IF;
      req_in.word  = if_addr_i[31:2];
      req_in.sel   = 4'b1111;
    end
  end

  always_comb begin
    issue       = lane_any && (state == MC_RD || state == MC_WR);
    capture     = pipe_vld[RD_LAT-1];
    cap_last    = capture && ((cap_cnt + 3'd1) == popcount4(cur.sel));
    asm_nxt     = asm_q;
    if (capture) asm_nxt[{pipe_lane[RD_LAT-1], 3'b000} +: 8] = ram_din_i;
    grant_owner = (state == MC_IDLE) ? req_in.owner : cur.owner;
    state_nxt   = state;
    case (state)
      MC_IDLE: begin
        if (mem_ce_i || if_req_i) begin
          if (req_in.sel == 4'b0000) state_nxt = MC_DONE;
          else if (req_in.we)        state_nxt = MC_WR;
          else                       state_nxt = MC_RD;
        end
      end
      MC_RD:   if (cap_last)  state_nxt = MC_DONE;
      MC_WR:   if (lane_last) state_nxt = MC_DONE;
      default: state_nxt = MC_IDLE;
    endcase
    fin = (state != MC_DONE) && (state_nxt == MC_DONE);
  end

  // Lane i carries data[8i+7:8i] and lives at byte offset 3-i of the word.
  assign ram_addr_o  = issue ? {cur.word, 2'd3 - lane} : ZERO_WORD;
  assign ram_we_o    = issue && (state == MC_WR);
  assign ram_dout_o  = ram_we_o ? cur.wdata[{lane, 3'b000} +: 8] : 8'h00;
  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign mem_data_o  = mem_data_q;
  assign mem_done_o  = mem_done_q;
  assign stall_req_o = (mem_ce_i & ~mem_done_o) | (if_req_i & ~if_done_o);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= MC_IDLE;
      cur        <= '0;
      visited    <= 4'b0000;
      cap_cnt    <= 3'd0;
      asm_q      <= ZERO_WORD;
      if_data_q  <= ZERO_WORD;
      mem_data_q <= ZERO_WORD;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_lane[i] <= 2'd0;
      end
    end else begin
      state <= state_nxt;
      if (state == MC_IDLE) cur <= req_in;
      if (issue)                                  visited <= visited | (4'b0001 << lane);
      else if (!(state == MC_RD || state == MC_WR)) visited <= 4'b0000;
      cap_cnt      <= (state == MC_RD) ? cap_cnt + {2'b00, capture} : 3'd0;
      asm_q        <= (state == MC_RD) ? asm_nxt : ZERO_WORD;
      pipe_vld[0]  <= issue && (state == MC_RD);
      pipe_lane[0] <= lane;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_lane[i] <= pipe_lane[i-1];
      end
      if_done_q  <= fin && (grant_owner == OWN_IF);
      mem_done_q <= fin && (grant_owner == OWN_MEM);
      if_data_q  <= (fin && (grant_owner == OWN_IF))  ? asm_nxt : ZERO_WORD;
      mem_data_q <= (fin && (grant_owner == OWN_MEM)) ? asm_nxt : ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (RD_LAT 1 and 3) share a byte RAM; each scenario is planned into
// per-cycle expectations from the byte-order/timing rules and a reference memory, then replayed and compared.
module tb_mem_ctrl;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a   [2];
  logic        ifr_a    [2];
  logic [31:0] ifaddr_a [2];
  logic [31:0] ifdata_a [2];
  logic        ifdone_a [2];
  logic        mce_a    [2];
  logic        mwe_a    [2];
  logic [31:0] maddr_a  [2];
  logic [3:0]  msel_a   [2];
  logic [31:0] mdi_a    [2];
  logic [31:0] mdo_a    [2];
  logic        mdone_a  [2];
  logic [31:0] raddr_a  [2];
  logic        rwe_a    [2];
  logic [7:0]  rdout_a  [2];
  logic [7:0]  rdin_a   [2];
  logic        stall_a  [2];

  logic [7:0] phys  [logic [31:0]];
  logic [7:0] model [logic [31:0]];
  logic [7:0] rp [2][3];

  logic [31:0] e_addr [W];
  logic        e_we   [W];
  logic [7:0]  e_dout [W];
  logic        e_mdone[W];
  logic        e_idone[W];
  logic [31:0] e_mdata[W];
  logic [31:0] e_idata[W];
  logic        q_mce  [W];
  logic        q_ifr  [W];
  logic        q_rstn [W];

  int vectors = 0;
  int misc    = 0;
  int cur_u   = 0;
  int cur_r   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    mem_ctrl #(.RD_LAT(L)) u_dut (
      .clk         (clk),
      .rst         (rstn_a[g]),
      .if_req_i    (ifr_a[g]),
      .if_addr_i   (ifaddr_a[g]),
      .if_data_o   (ifdata_a[g]),
      .if_done_o   (ifdone_a[g]),
      .mem_ce_i    (mce_a[g]),
      .mem_we_i    (mwe_a[g]),
      .mem_addr_i  (maddr_a[g]),
      .mem_sel_i   (msel_a[g]),
      .mem_data_i  (mdi_a[g]),
      .mem_data_o  (mdo_a[g]),
      .mem_done_o  (mdone_a[g]),
      .ram_addr_o  (raddr_a[g]),
      .ram_we_o    (rwe_a[g]),
      .ram_dout_o  (rdout_a[g]),
      .ram_din_i   (rdin_a[g]),
      .stall_req_o (stall_a[g])
    );
    assign rdin_a[g] = rp[g][L-1];
  end

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Byte RAM: read data emerges RD_LAT cycles after its address.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      rp[g][2] <= rp[g][1];
      rp[g][1] <= rp[g][0];
      rp[g][0] <= phys.exists(raddr_a[g]) ? phys[raddr_a[g]] : dflt(raddr_a[g]);
      if (rwe_a[g] === 1'b1) phys[raddr_a[g]] = rdout_a[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s u%0d cyc%0d obs=%08h exp=%08h", tag, cur_u, cur_r, obs, exp);
    end
  endtask

  task automatic clear_from(input int r0);
    for (int r = r0; r < W; r++) begin
      e_addr[r] = '0; e_we[r] = 1'b0; e_dout[r] = '0;
      e_mdone[r] = 1'b0; e_idone[r] = 1'b0; e_mdata[r] = '0; e_idata[r] = '0;
    end
  endtask

  task automatic clr();
    clear_from(0);
    for (int r = 0; r < W; r++) begin
      q_mce[r] = 1'b0; q_ifr[r] = 1'b0; q_rstn[r] = 1'b1;
    end
  endtask

  // Expected trace of one granted request seen in IDLE at cycle s; d returns its done cycle.
  task automatic plan(input int s, input bit is_mem, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] dat, input int lat, output int d);
    logic [31:0] base, a, word;
    int k;
    base = {addr[31:2], 2'b00};
    word = '0;
    k    = 0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) begin
        a = base + 32'(3 - i);
        e_addr[s+1+k] = a;
        e_we[s+1+k]   = we;
        if (we) begin
          e_dout[s+1+k] = dat[8*i +: 8];
          model[a]      = dat[8*i +: 8];
        end else begin
          word[8*i +: 8] = model.exists(a) ? model[a] : dflt(a);
        end
        k++;
      end
    end
    if (k == 0)  d = s + 1;
    else if (we) d = s + k + 1;
    else         d = s + k + lat + 1;
    if (is_mem) begin e_mdone[d] = 1'b1; e_mdata[d] = word; end
    else        begin e_idone[d] = 1'b1; e_idata[d] = word; end
  endtask

  task automatic run(input int u, input int n, input logic mwe, input logic [31:0] maddr,
                     input logic [3:0] msel, input logic [31:0] mdat, input logic [31:0] faddr);
    cur_u = u;
    for (int r = 0; r < n; r++) begin
      @(posedge clk);
      #1;
      cur_r       = r;
      rstn_a[u]   = q_rstn[r];
      mce_a[u]    = q_mce[r];
      ifr_a[u]    = q_ifr[r];
      mwe_a[u]    = mwe;
      maddr_a[u]  = maddr;
      msel_a[u]   = msel;
      mdi_a[u]    = mdat;
      ifaddr_a[u] = faddr;
      #1;
      chk("ram_addr", raddr_a[u], e_addr[r]);
      chk("ram_we", 32'(rwe_a[u]), 32'(e_we[r]));
      if (e_we[r]) chk("ram_dout", 32'(rdout_a[u]), 32'(e_dout[r]));
      chk("mem_done", 32'(mdone_a[u]), 32'(e_mdone[r]));
      chk("if_done", 32'(ifdone_a[u]), 32'(e_idone[r]));
      chk("mem_data", mdo_a[u], e_mdata[r]);
      chk("if_data", ifdata_a[u], e_idata[r]);
      if (q_rstn[r])
        chk("stall", 32'(stall_a[u]),
            32'((q_mce[r] & ~e_mdone[r]) | (q_ifr[r] & ~e_idone[r])));
    end
  endtask

  task automatic scen(input int u, input bit m_on, input bit f_on, input bit f_first, input int m_raise,
                      input logic mwe, input logic [31:0] maddr, input logic [3:0] msel,
                      input logic [31:0] mdat, input logic [31:0] faddr);
    int lat, dm, df;
    lat = (u == 0) ? 1 : 3;
    dm  = 0;
    df  = 0;
    clr();
    if (f_on && (f_first || !m_on)) begin
      plan(0, 1'b0, 1'b0, faddr, 4'hF, 32'h0, lat, df);
      for (int r = 0; r <= df; r++) q_ifr[r] = 1'b1;
      if (m_on) begin
        plan(df + 1, 1'b1, mwe, maddr, msel, mdat, lat, dm);
        for (int r = m_raise; r <= dm; r++) q_mce[r] = 1'b1;
      end
    end else begin
      plan(0, 1'b1, mwe, maddr, msel, mdat, lat, dm);
      for (int r = 0; r <= dm; r++) q_mce[r] = 1'b1;
      if (f_on) begin
        plan(dm + 1, 1'b0, 1'b0, faddr, 4'hF, 32'h0, lat, df);
        for (int r = 0; r <= df; r++) q_ifr[r] = 1'b1;
      end
    end
    run(u, ((dm > df) ? dm : df) + 2, mwe, maddr, msel, mdat, faddr);
  endtask

  initial begin
    int d0;
    for (int u = 0; u < 2; u++) begin
      rstn_a[u] = 1'b0; ifr_a[u] = 1'b0; ifaddr_a[u] = '0; mce_a[u] = 1'b0;
      mwe_a[u] = 1'b0; maddr_a[u] = '0; msel_a[u] = '0; mdi_a[u] = '0;
    end

    // Reset state of both instances.
    clr();
    q_rstn[0] = 1'b0; q_rstn[1] = 1'b0;
    run(0, 4, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    run(1, 4, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

    // Reset in the middle of a load, then the held request restarts from base+0.
    clr();
    plan(0, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1, d0);
    clear_from(3);
    q_rstn[2] = 1'b0; q_rstn[3] = 1'b0;
    plan(4, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1, d0);
    for (int r = 0; r <= d0; r++) q_mce[r] = 1'b1;
    run(0, d0 + 2, 1'b0, 32'h300, 4'hF, 32'h0, 32'h0);

    // Directed cases.
    scen(0, 1, 0, 0, 0, 1'b1, 32'h100, 4'hF,    32'h11223344, 32'h0);
    scen(0, 1, 0, 0, 0, 1'b0, 32'h100, 4'hF,    32'h0,        32'h0);
    scen(0, 1, 0, 0, 0, 1'b1, 32'h203, 4'b0001, 32'hABABABAB, 32'h0);
    scen(0, 1, 1, 0, 0, 1'b0, 32'h10,  4'b1100, 32'h0,        32'h40);
    scen(0, 1, 1, 1, 2, 1'b1, 32'h84,  4'hF,    32'hCAFEF00D, 32'h80);
    scen(0, 1, 0, 0, 0, 1'b0, 32'h500, 4'b0000, 32'h0,        32'h0);
    scen(0, 1, 0, 0, 0, 1'b1, 32'h504, 4'b0000, 32'h12345678, 32'h0);
    scen(0, 0, 1, 0, 0, 1'b0, 32'h0,   4'h0,    32'h0,        32'h102);
    scen(1, 1, 0, 0, 0, 1'b0, 32'h100, 4'hF,    32'h0,        32'h0);
    scen(1, 1, 0, 0, 0, 1'b0, 32'hFFFFFFFE, 4'b0110, 32'h0,   32'h0);

    // Randomised traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      int          u, mr;
      bit          fon, ffirst, mon;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr, faddr, dat;
      u      = ($urandom_range(0, 3) == 0) ? 1 : 0;
      fon    = 1'($urandom_range(0, 2) == 0);
      mon    = fon ? 1'($urandom_range(0, 1)) : 1'b1;
      ffirst = 1'($urandom_range(0, 1));
      mr     = $urandom_range(1, 4);
      we     = 1'($urandom_range(0, 1));
      sel    = 4'($urandom_range(0, 15));
      dat    = $urandom;
      addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                           : 32'h1000 + 32'($urandom_range(0, 63));
      faddr  = 32'h1000 + 32'($urandom_range(0, 63));
      scen(u, mon, fon, ffirst, mr, we, addr, sel, dat, faddr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
